writeback_stage: RTL
====================

// Module: writeback_stage
// PURPOSE
//  Y86-64 pipeline M->W register plus write-back logic, directly downstream of memory_access.
//  Latches memory-stage results and drives both register-file write ports.
//  Tracks processor status (RUN/HALT/ERR) and counts retired instructions.
//  Exports W-stage values for decode forwarding and a halt flag for upstream freeze.
// PARAMETERS
//  DATA_W    64     width of valE/valM
//  CNT_W     32     width of retired-instruction counter
//  REG_NONE  4'hF   "no register" destination code
// PORTS
//  clk_i         in   1       clock, all state updates on posedge
//  rst_i         in   1       synchronous reset, active-high
//  W_stall_i     in   1       hold W register contents
//  W_bubble_i    in   1       load bubble into W register
//  M_icode_i     in   4       icode of instruction in M
//  M_dstE_i      in   4       E destination register
//  M_dstM_i      in   4       M destination register
//  M_valE_i      in   DATA_W  ALU result from M
//  m_valM_i      in   DATA_W  memory read data (memory_access m_valM_o)
//  m_stat_i      in   3       status after memory access (memory_access m_stat_o)
//  W_valid_o     out  1       W holds a real instruction (0 = bubble)
//  W_icode_o     out  4       registered icode
//  W_dstE_o      out  4       registered dstE (forwarding)
//  W_dstM_o      out  4       registered dstM (forwarding)
//  W_valE_o      out  DATA_W  registered valE (forwarding)
//  W_valM_o      out  DATA_W  registered valM (forwarding)
//  wb_enE_o      out  1       regfile port E write enable
//  wb_enM_o      out  1       regfile port M write enable
//  proc_stat_o   out  3       processor status, `SAOK/`SHLT/`SADR/`SINS
//  halted_o      out  1       1 in HALT or ERR
//  retired_o     out  CNT_W   retired-instruction count
// BEHAVIOUR
//  Reset: W_valid=0, W_icode=`INOP, W_dstE=W_dstM=REG_NONE, W_valE=W_valM=0, W stat=`SAOK,
//   state=RUN, proc_stat=`SAOK, halted=0, retired=0. Status codes per define.v:
//   SAOK=1, SHLT=2, SADR=3, SINS=4.
//  W register (1-cycle latency): priority rst_i > W_stall_i (hold) > W_bubble_i > load.
//   Bubble: valid=0, icode=`INOP, dsts=REG_NONE, vals=0, stat=`SAOK. Load: valid=1, capture all M/m inputs.
//  Frozen: in HALT/ERR the W register holds regardless of stall/bubble.
//  Write-back is combinational from W:
//   wb_enM = valid & stat==`SAOK & state==RUN & dstM!=REG_NONE.
//   wb_enE = same condition on dstE, forced 0 when dstE==dstM (M port wins, popq %rsp).
//   Enables remain asserted while stalled; the rewrite is idempotent.
//  FSM (registered), states RUN, HALT, ERR:
//   RUN->HALT when valid & stat==`SHLT.
//   RUN->ERR  when valid & stat in {`SADR,`SINS}.
//   HALT/ERR are terminal until rst_i.
//   proc_stat = `SAOK in RUN, otherwise the captured code. halted = state!=RUN.
//   Both update on the edge after the faulting instruction sits in W.
//  Any other non-AOK stat value also goes to ERR and reports `SINS.
//  Retire counter: +1 on an edge where state==RUN & valid & stat==`SAOK & !W_stall_i.
//   Saturates at all-ones; frozen in HALT/ERR.
//   The faulting or halting instruction is not counted.
//  A bubble never writes, never retires, and never changes state.
// TESTING
//  T1 reset: hold rst_i 2 cycles -> W_dstE=W_dstM=4'hF, wb_en*=0, proc_stat=1, halted=0, retired=0.
//  T2 rrmovq: icode=2, dstE=3, dstM=F, valE=0x1234, stat=1 -> next cycle W_valE=0x1234,
//   wb_enE=1, wb_enM=0; retired=1 one edge later.
//  T3 popq %rsp: dstE=4, dstM=4, valE=0x108, valM=0xAA, stat=1 -> wb_enE=0, wb_enM=1, W_valM=0xAA.
//  T4 bad mrmovq: m_stat=3, dstM=5 -> wb_enM=0; next edge proc_stat=3, halted=1;
//   later AOK inputs ignored, W frozen, retired unchanged.
//  T5 stall/bubble: valid instr, stall 3 cycles -> W held, retired +1 only after stall drops;
//   stall+bubble together -> hold; bubble alone -> W_valid=0, no write, retired unchanged.
//  T6 halt then reset mid-halt: stat=2 -> proc_stat=2, halted=1;
//   rst_i 1 cycle -> RUN, proc_stat=1, retired=0.

Source files
------------

// File: rtl/writeback_stage.sv
// Y86-64 M->W pipeline register with register-file write-back, processor
// status FSM (RUN/HALT/ERR) and a saturating retired-instruction counter.
module writeback_stage #(
    parameter int          DATA_W   = 64,
    parameter int          CNT_W    = 32,
    parameter logic [3:0]  REG_NONE = 4'hF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              W_stall_i,
    input  logic              W_bubble_i,
    input  logic [3:0]        M_icode_i,
    input  logic [3:0]        M_dstE_i,
    input  logic [3:0]        M_dstM_i,
    input  logic [DATA_W-1:0] M_valE_i,
    input  logic [DATA_W-1:0] m_valM_i,
    input  logic [2:0]        m_stat_i,
    output logic              W_valid_o,
    output logic [3:0]        W_icode_o,
    output logic [3:0]        W_dstE_o,
    output logic [3:0]        W_dstM_o,
    output logic [DATA_W-1:0] W_valE_o,
    output logic [DATA_W-1:0] W_valM_o,
    output logic              wb_enE_o,
    output logic              wb_enM_o,
    output logic [2:0]        proc_stat_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  retired_o
);

    localparam logic [3:0] INOP = 4'h1;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [1:0] {RUN, HALT, ERR} state_t;

    state_t              state_q, state_d;
    logic [2:0]          code_q, code_d;
    logic                w_valid_q;
    logic [3:0]          w_icode_q, w_dstE_q, w_dstM_q;
    logic [DATA_W-1:0]   w_valE_q, w_valM_q;
    logic [2:0]          w_stat_q;
    logic [CNT_W-1:0]    retired_q;
    logic                w_ok;

    // The W register stops moving once the processor leaves RUN.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_valid_q <= 1'b0;
            w_icode_q <= INOP;
            w_dstE_q  <= REG_NONE;
            w_dstM_q  <= REG_NONE;
            w_valE_q  <= '0;
            w_valM_q  <= '0;
            w_stat_q  <= SAOK;
        end else if (W_stall_i || state_q != RUN) begin
            w_valid_q <= w_valid_q;
        end else if (W_bubble_i) begin
            w_valid_q <= 1'b0;
            w_icode_q <= INOP;
            w_dstE_q  <= REG_NONE;
            w_dstM_q  <= REG_NONE;
            w_valE_q  <= '0;
            w_valM_q  <= '0;
            w_stat_q  <= SAOK;
        end else begin
            w_valid_q <= 1'b1;
            w_icode_q <= M_icode_i;
            w_dstE_q  <= M_dstE_i;
            w_dstM_q  <= M_dstM_i;
            w_valE_q  <= M_valE_i;
            w_valM_q  <= m_valM_i;
            w_stat_q  <= m_stat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            code_q  <= SAOK;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    // Unknown status codes are reported as an invalid instruction.
    // NOTE: defaults come first so every path assigns every output and no
    // latch is inferred.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        if (state_q == RUN && w_valid_q && w_stat_q != SAOK) begin
            case (w_stat_q)
                SHLT: begin
                    state_d = HALT;
                    code_d  = SHLT;
                end
                SADR: begin
                    state_d = ERR;
                    code_d  = SADR;
                end
                default: begin
                    state_d = ERR;
                    code_d  = SINS;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retired_q <= '0;
        end else if (w_ok && !W_stall_i && retired_q != '1) begin
            retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // popq %rsp names the same register twice; the loaded value (port M) wins.
    assign w_ok     = w_valid_q && w_stat_q == SAOK && state_q == RUN;
    assign wb_enM_o = w_ok && w_dstM_q != REG_NONE;
    assign wb_enE_o = w_ok && w_dstE_q != REG_NONE && w_dstE_q != w_dstM_q;

    assign W_valid_o   = w_valid_q;
    assign W_icode_o   = w_icode_q;
    assign W_dstE_o    = w_dstE_q;
    assign W_dstM_o    = w_dstM_q;
    assign W_valE_o    = w_valE_q;
    assign W_valM_o    = w_valM_q;
    assign proc_stat_o = (state_q == RUN) ? SAOK : code_q;
    assign halted_o    = state_q != RUN;
    assign retired_o   = retired_q;

endmodule
